// File: rtl/elevator_req_sched.sv
// Hall/cabin request latch with SCAN (up-then-down) next-floor scheduler.
// Optional macro REQ_CANCEL_EN: a cabin double-press cancels its pending request.
module elevator_req_sched #(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_FLOORS-1:0] i_req_ext,
    input  logic [NUM_FLOORS-1:0] i_req_inter,
    input  logic [FLOOR_W-1:0]    i_cur_floor,
    input  logic                  i_door_open,
    input  logic                  i_moving_up,
    input  logic                  i_moving_down,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic [NUM_FLOORS-1:0] o_target_onehot,
    output logic [FLOOR_W-1:0]    o_target_floor,
    output logic                  o_target_valid,
    output logic [1:0]            o_scan_dir
);

    localparam int unsigned NF = NUM_FLOORS;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   ext_prev_q, ext_prev_d;
    logic [NUM_FLOORS-1:0]   int_prev_q, int_prev_d;
    logic [NUM_FLOORS-1:0]   pend_ext_q, pend_ext_d;
    logic [NUM_FLOORS-1:0]   pend_int_q, pend_int_d;
    logic [FLOOR_W-1:0]      tgt_floor_q, tgt_floor_d;
    logic                    tgt_valid_q, tgt_valid_d;

    logic [NUM_FLOORS-1:0]   prs_ext, prs_int, clr, pend, above, below;
    logic                    in_range, serve, here, have_up, have_dn, found_up, go_up;
    logic [FLOOR_W-1:0]      up_floor, dn_floor;
    int unsigned             cur_idx;

    always_comb begin
        prs_ext  = i_req_ext & ~ext_prev_q;
        prs_int  = i_req_inter & ~int_prev_q;
        cur_idx  = 32'(i_cur_floor);
        in_range = cur_idx < NF;
        serve    = i_door_open & ~i_moving_up & ~i_moving_down & in_range;
        clr      = serve ? (NUM_FLOORS'(1) << i_cur_floor) : '0;

        ext_prev_d = i_req_ext;
        int_prev_d = i_req_inter;
        // Clear is applied last so a service at this floor beats a same-edge press.
        pend_ext_d = (pend_ext_q | prs_ext) & ~clr;
`ifdef REQ_CANCEL_EN
        pend_int_d = (pend_int_q ^ prs_int) & ~clr;
`else
        pend_int_d = (pend_int_q | prs_int) & ~clr;
`endif

        // Scheduling looks only at requests already registered before this edge.
        pend     = pend_ext_q | pend_int_q;
        above    = '0;
        below    = '0;
        here     = 1'b0;
        found_up = 1'b0;
        up_floor = '0;
        dn_floor = '0;
        for (int unsigned f = 0; f < NF; f++) begin
            if (f > cur_idx) above[f] = pend[f];
            if (f < cur_idx) below[f] = pend[f];
            if (f == cur_idx) here = pend[f];
            if (above[f] && !found_up) begin
                up_floor = FLOOR_W'(f);
                found_up = 1'b1;
            end
            if (below[f]) dn_floor = FLOOR_W'(f);
        end
        have_up = |above;
        have_dn = |below;
        go_up   = have_up && ((state_q != S_DOWN) || !have_dn);

        state_d     = state_q;
        tgt_floor_d = tgt_floor_q;
        tgt_valid_d = tgt_valid_q;
        if (in_range) begin
            if (go_up) begin
                state_d     = S_UP;
                tgt_floor_d = up_floor;
                tgt_valid_d = 1'b1;
            end else if (have_dn) begin
                state_d     = S_DOWN;
                tgt_floor_d = dn_floor;
                tgt_valid_d = 1'b1;
            end else if (here) begin
                state_d     = S_IDLE;
                tgt_floor_d = i_cur_floor;
                tgt_valid_d = 1'b1;
            end else begin
                state_d     = S_IDLE;
                tgt_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            ext_prev_q  <= '0;
            int_prev_q  <= '0;
            pend_ext_q  <= '0;
            pend_int_q  <= '0;
            tgt_floor_q <= '0;
            tgt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_prev_q  <= ext_prev_d;
            int_prev_q  <= int_prev_d;
            pend_ext_q  <= pend_ext_d;
            pend_int_q  <= pend_int_d;
            tgt_floor_q <= tgt_floor_d;
            tgt_valid_q <= tgt_valid_d;
        end
    end

    assign o_pending       = pend_ext_q | pend_int_q;
    assign o_target_floor  = tgt_floor_q;
    assign o_target_valid  = tgt_valid_q;
    assign o_target_onehot = tgt_valid_q ? (NUM_FLOORS'(1) << tgt_floor_q) : '0;
    assign o_scan_dir      = state_q;

endmodule

// File: tb/tb_elevator_req_sched.sv
// Vector-table bench for elevator_req_sched: expected records queued at drive, checked after the edge.
module tb_elevator_req_sched;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] i_req_ext, i_req_inter;
    logic [2:0] i_cur_floor;
    logic       i_door_open, i_moving_up, i_moving_down;
    logic [4:0] o_pending, o_target_onehot;
    logic [2:0] o_target_floor;
    logic       o_target_valid;
    logic [1:0] o_scan_dir;

    elevator_req_sched #(.NUM_FLOORS(5), .FLOOR_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .i_req_ext(i_req_ext), .i_req_inter(i_req_inter),
        .i_cur_floor(i_cur_floor), .i_door_open(i_door_open),
        .i_moving_up(i_moving_up), .i_moving_down(i_moving_down),
        .o_pending(o_pending), .o_target_onehot(o_target_onehot),
        .o_target_floor(o_target_floor), .o_target_valid(o_target_valid),
        .o_scan_dir(o_scan_dir)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] ext;
        logic [4:0] inter;
        logic [2:0] cur;
        logic       door, up, down;
        logic [4:0] pend;
        logic [1:0] dir;
        logic [2:0] flr;
        logic       vld;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic v(input logic [4:0] ext, input logic [4:0] inter, input logic [2:0] cur,
                     input logic door, input logic up, input logic down,
                     input logic [4:0] pend, input logic [1:0] dir,
                     input logic [2:0] flr, input logic vld);
        vec_t r;
        r.ext = ext; r.inter = inter; r.cur = cur;
        r.door = door; r.up = up; r.down = down;
        r.pend = pend; r.dir = dir; r.flr = flr; r.vld = vld;
        tbl.push_back(r);
    endtask

    task automatic cmp(input string tag, input int idx, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", tag, idx, act, req);
        end
    endtask

    task automatic check_outs(input int idx, input vec_t e);
        logic [4:0] oh;
        oh = e.vld ? (5'b00001 << e.flr) : 5'b00000;
        cmp("pending", idx, {3'b0, o_pending}, {3'b0, e.pend});
        cmp("scan_dir", idx, {6'b0, o_scan_dir}, {6'b0, e.dir});
        cmp("target_valid", idx, {7'b0, o_target_valid}, {7'b0, e.vld});
        cmp("target_onehot", idx, {3'b0, o_target_onehot}, {3'b0, oh});
        if (e.vld) cmp("target_floor", idx, {5'b0, o_target_floor}, {5'b0, e.flr});
        else       cmp("target_floor_hold", idx, {5'b0, o_target_floor}, {5'b0, e.flr});
    endtask

    task automatic step(input int idx, input vec_t r);
        vec_t e;
        @(negedge CLK);
        i_req_ext     = r.ext;
        i_req_inter   = r.inter;
        i_cur_floor   = r.cur;
        i_door_open   = r.door;
        i_moving_up   = r.up;
        i_moving_down = r.down;
        exp_q.push_back(r);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
        end else begin
            e = exp_q.pop_front();
            check_outs(idx, e);
        end
    endtask

    initial begin
        RST = 1'b0;
        i_req_ext = '0; i_req_inter = '0; i_cur_floor = '0;
        i_door_open = 1'b0; i_moving_up = 1'b0; i_moving_down = 1'b0;

        //   ext      inter    cur  dr up dn  pend     dir    flr  vld
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 0);
        v(5'b01000, 5'b00000, 3'd0, 0, 0, 0, 5'b01000, 2'b00, 3'd0, 0);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b01000, 2'b01, 3'd3, 1);
        v(5'b00000, 5'b00000, 3'd3, 1, 0, 0, 5'b00000, 2'b00, 3'd3, 1);
        v(5'b00000, 5'b00000, 3'd3, 0, 0, 0, 5'b00000, 2'b00, 3'd3, 0);
        // scan ordering
        v(5'b10001, 5'b01000, 3'd2, 0, 0, 0, 5'b11001, 2'b00, 3'd3, 0);
        v(5'b00000, 5'b00000, 3'd2, 0, 0, 0, 5'b11001, 2'b01, 3'd3, 1);
        v(5'b00000, 5'b00000, 3'd2, 0, 0, 0, 5'b11001, 2'b01, 3'd3, 1);
        v(5'b00000, 5'b00000, 3'd3, 1, 0, 0, 5'b10001, 2'b01, 3'd4, 1);
        v(5'b00000, 5'b00000, 3'd4, 0, 1, 0, 5'b10001, 2'b10, 3'd0, 1);
        v(5'b00000, 5'b00000, 3'd4, 1, 0, 0, 5'b00001, 2'b10, 3'd0, 1);
        v(5'b00000, 5'b00000, 3'd2, 0, 0, 1, 5'b00001, 2'b10, 3'd0, 1);
        v(5'b00000, 5'b00000, 3'd0, 1, 0, 0, 5'b00000, 2'b00, 3'd0, 1);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 0);
        // held cabin button across a service clear
        v(5'b00000, 5'b00010, 3'd1, 0, 0, 0, 5'b00010, 2'b00, 3'd0, 0);
        v(5'b00000, 5'b00010, 3'd1, 1, 0, 0, 5'b00000, 2'b00, 3'd1, 1);
        for (int i = 0; i < 8; i++)
            v(5'b00000, 5'b00010, 3'd1, 0, 0, 0, 5'b00000, 2'b00, 3'd1, 0);
        v(5'b00000, 5'b00000, 3'd1, 0, 0, 0, 5'b00000, 2'b00, 3'd1, 0);
        v(5'b00000, 5'b00010, 3'd1, 0, 0, 0, 5'b00010, 2'b00, 3'd1, 0);
        v(5'b00000, 5'b00000, 3'd1, 0, 0, 0, 5'b00010, 2'b00, 3'd1, 1);
        v(5'b00000, 5'b00000, 3'd1, 1, 0, 0, 5'b00000, 2'b00, 3'd1, 1);
        v(5'b00000, 5'b00000, 3'd1, 0, 0, 0, 5'b00000, 2'b00, 3'd1, 0);
        // clear beats a same-edge press at the serviced floor
        v(5'b00100, 5'b00000, 3'd2, 1, 0, 0, 5'b00000, 2'b00, 3'd1, 0);
        v(5'b00100, 5'b00000, 3'd2, 0, 0, 0, 5'b00000, 2'b00, 3'd1, 0);
        v(5'b00000, 5'b00000, 3'd2, 0, 0, 0, 5'b00000, 2'b00, 3'd1, 0);
        // out-of-range floor holds everything
        v(5'b00100, 5'b00000, 3'd0, 0, 0, 0, 5'b00100, 2'b00, 3'd1, 0);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b00100, 2'b01, 3'd2, 1);
        v(5'b00000, 5'b00000, 3'd7, 1, 0, 0, 5'b00100, 2'b01, 3'd2, 1);
        v(5'b00000, 5'b00000, 3'd2, 1, 0, 0, 5'b00000, 2'b00, 3'd2, 1);
        v(5'b00000, 5'b00000, 3'd2, 0, 0, 0, 5'b00000, 2'b00, 3'd2, 0);
        // downward sweep keeps direction while a request waits behind
        v(5'b00011, 5'b00000, 3'd4, 0, 0, 0, 5'b00011, 2'b00, 3'd2, 0);
        v(5'b00000, 5'b00000, 3'd4, 0, 0, 1, 5'b00011, 2'b10, 3'd1, 1);
        v(5'b00000, 5'b10000, 3'd3, 0, 0, 1, 5'b10011, 2'b10, 3'd1, 1);
        v(5'b00000, 5'b00000, 3'd2, 0, 0, 1, 5'b10011, 2'b10, 3'd1, 1);
        v(5'b00000, 5'b00000, 3'd1, 1, 0, 0, 5'b10001, 2'b10, 3'd0, 1);
        v(5'b00000, 5'b00000, 3'd0, 1, 0, 0, 5'b10000, 2'b01, 3'd4, 1);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b10000, 2'b01, 3'd4, 1);
        v(5'b00000, 5'b00000, 3'd4, 1, 0, 0, 5'b00000, 2'b00, 3'd4, 1);
        v(5'b00000, 5'b00000, 3'd4, 0, 0, 0, 5'b00000, 2'b00, 3'd4, 0);
        // cabin double press
        v(5'b00000, 5'b10000, 3'd0, 0, 0, 0, 5'b10000, 2'b00, 3'd4, 0);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b10000, 2'b01, 3'd4, 1);
`ifdef REQ_CANCEL_EN
        v(5'b00000, 5'b10000, 3'd0, 0, 0, 0, 5'b00000, 2'b01, 3'd4, 1);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b00000, 2'b00, 3'd4, 0);
        v(5'b00000, 5'b00000, 3'd4, 1, 0, 0, 5'b00000, 2'b00, 3'd4, 0);
`else
        v(5'b00000, 5'b10000, 3'd0, 0, 0, 0, 5'b10000, 2'b01, 3'd4, 1);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b10000, 2'b01, 3'd4, 1);
        v(5'b00000, 5'b00000, 3'd4, 1, 0, 0, 5'b00000, 2'b00, 3'd4, 1);
`endif
        v(5'b00000, 5'b00000, 3'd4, 0, 0, 0, 5'b00000, 2'b00, 3'd4, 0);
        // set up traffic for the mid-operation reset
        v(5'b10110, 5'b00000, 3'd0, 0, 0, 0, 5'b10110, 2'b00, 3'd4, 0);
        v(5'b00000, 5'b00000, 3'd0, 0, 0, 0, 5'b10110, 2'b01, 3'd1, 1);

        repeat (2) @(posedge CLK);
        #1;
        begin
            vec_t z;
            z = '{default: '0};
            check_outs(-1, z);
        end
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        // asynchronous reset in the middle of a cycle
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        begin
            vec_t z;
            z = '{default: '0};
            check_outs(100, z);
        end
        @(negedge CLK);
        RST = 1'b1;
        begin
            vec_t r;
            r = '{default: '0};
            step(101, r);
            step(102, r);
            r.ext = 5'b00100; r.pend = 5'b00100;
            step(103, r);
            r.ext = 5'b00000; r.dir = 2'b01; r.flr = 3'd2; r.vld = 1'b1;
            step(104, r);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elevator_req_sched.md
Name: elevator_req_sched

Overview:
Request latch and next-floor scheduler placed directly upstream of the elevator controller.
- Captures hall (external) and cabin (internal) button presses and holds them until served.
- Runs a SCAN (up-then-down) policy to choose one target floor.
- Presents that target one-hot to the controller's request input. Consumes the controller's current-floor, direction and door outputs to retire served requests.

Parameters:
NUM_FLOORS, 5, number of floors; floor indices 0..NUM_FLOORS-1.
FLOOR_W, 3, width of floor-index buses; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
CLK  input  1  system clock, rising-edge.
RST  input  1  asynchronous active-low reset.
i_req_ext  input  NUM_FLOORS  hall buttons, level, bit n = floor n.
i_req_inter  input  NUM_FLOORS  cabin buttons, level, bit n = floor n.
i_cur_floor  input  FLOOR_W  controller current floor.
i_door_open  input  1  controller door-open indication.
i_moving_up  input  1  controller up indication.
i_moving_down  input  1  controller down indication.
o_pending  output  NUM_FLOORS  OR of pending_ext and pending_int.
o_target_onehot  output  NUM_FLOORS  one-hot target to the controller; 0 when invalid.
o_target_floor  output  FLOOR_W  binary target index.
o_target_valid  output  1  target is meaningful.
o_scan_dir  output  2  scan state: 00 IDLE, 01 UP, 10 DOWN.

Behaviour:
- Reset (RST=0, asynchronous), all outputs and registers 0:
  - pending_ext, pending_int, edge-detect history.
  - o_target_*, o_scan_dir=IDLE.
  - Release is synchronous to the next CLK edge.
- Edge detect: a press is a 0->1 transition of a button bit between consecutive CLK samples. Held levels do not re-trigger.
- Pending set: a press sampled at edge k sets the corresponding pending bit visible after edge k. Ext and inter are tracked separately.
- Service clear:
  - Condition: at an edge where i_door_open=1, i_moving_up=0, i_moving_down=0 and i_cur_floor<NUM_FLOORS.
  - Action: bits [i_cur_floor] of both pending vectors are cleared.
  - Clear beats a simultaneous press at the same floor.
- Out-of-range i_cur_floor (>=NUM_FLOORS):
  - No clear is performed.
  - FSM holds its state.
  - Target registers hold their values.
- Scan FSM, evaluated each edge on the registered pending vector P and i_cur_floor=c:
  - IDLE:
    - any P above c -> UP;
    - else any P below c -> DOWN;
    - else stay IDLE.
  - UP:
    - if any P above c, stay UP;
    - else if any P below c, go DOWN;
    - else IDLE.
  - DOWN: mirror of UP.
- Target selection, registered at the same edge as the FSM transition:
  - UP: nearest pending floor > c (lowest index above c).
  - DOWN: nearest pending floor < c (highest index below c).
  - IDLE with only P[c] set: target = c, valid=1.
  - IDLE with P==0: valid=0, onehot=0, floor holds its last value.
- Latency: press edge k -> o_pending at k; o_target_* and o_scan_dir update at k+1.
- Stability: the target never changes direction while o_scan_dir is UP or DOWN and a pending floor remains ahead; new requests behind the car wait for reversal.
- Multiple simultaneous presses in one cycle are all captured.
- o_target_onehot equals (1 << o_target_floor) when valid, otherwise 0.

Optional Feature:
REQ_CANCEL_EN:
- Defined: a press on i_req_inter[n] while pending_int[n] is already 1 clears pending_int[n] at that edge (cabin double-press cancel). pending_ext is unaffected. A service clear at the same edge also results in 0.
- Not defined: repeated presses on a pending bit are ignored; only service clears pending.

Test Plan:
- Reset: hold RST=0 mid-operation with pending=5'b10110 -> all outputs 0 immediately (asynchronously); after release, a press is needed to set anything.
- Single request: c=0, press i_req_ext=5'b01000 -> o_pending=5'b01000 after that edge; next edge o_scan_dir=UP, o_target_floor=3, o_target_onehot=5'b01000, valid=1.
- SCAN ordering: c=2, scan UP, pending floors 0,4 and 3 -> target 3; set c=3 with door open and no motion -> bit 3 clears, target 4; after floor 4 served, dir=DOWN, target 0; after floor 0 served, IDLE, valid=0.
- Held button: keep i_req_inter[1]=1 for 10 cycles across a service clear at c=1 -> bit 1 not re-set while held; release and press again -> set again.
- Simultaneous clear/press: c=2, door open, stopped, press i_req_ext[2] on the same edge -> pending[2]=0; IDLE target floor 2 is never issued.
- REQ_CANCEL_EN: press i_req_inter[4], release, press again -> pending_int[4] 1 then 0, target valid drops. Without the macro it stays 1.
